// File: rtl/acc_requant.sv
// Requantization stage behind the MAC: bias add, rounding arithmetic shift,
// optional ReLU and saturation to a signed activation, in a 3-stage stallable pipeline.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module acc_requant #(
    parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
    parameter int unsigned ACC_WIDTH    = `ACC_WIDTH,
    parameter int unsigned SHIFT_WIDTH  = 5,
    parameter int unsigned SATCNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [ACC_WIDTH-1:0]    acc_in,
    input  logic signed [ACC_WIDTH-1:0]    bias,
    input  logic        [SHIFT_WIDTH-1:0]  shift,
    input  logic                           relu_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_data,
    output logic                           out_sat,
    input  logic                           sat_clear,
    output logic        [SATCNT_WIDTH-1:0] sat_count
);
    localparam int unsigned SW = ACC_WIDTH + 1;
    localparam int unsigned RW = ACC_WIDTH + 2;
    localparam logic signed [RW-1:0] MAX_V = $signed((RW'(1) << (DATA_WIDTH - 1)) - RW'(1));
    localparam logic signed [RW-1:0] MIN_V = -MAX_V - RW'(1);

    logic                           adv;

    logic                           s1_valid_q;
    logic signed [SW-1:0]           s1_sum_q;
    logic        [SHIFT_WIDTH-1:0]  s1_shift_q;
    logic                           s1_relu_q;

    logic                           s2_valid_q;
    logic signed [RW-1:0]           s2_r_q;
    logic                           s2_relu_q;

    logic                           out_valid_q;
    logic signed [DATA_WIDTH-1:0]   out_data_q;
    logic                           out_sat_q;
    logic        [SATCNT_WIDTH-1:0] sat_count_q;

    logic signed [SW-1:0]           sum_d;
    logic signed [RW-1:0]           rnd_d;
    logic signed [RW-1:0]           r_d;
    logic signed [RW-1:0]           relu_r;
    logic signed [DATA_WIDTH-1:0]   data_d;
    logic                           sat_d;
    logic        [SATCNT_WIDTH-1:0] sat_count_d;

    // Whole pipeline advances together; only a stalled valid output blocks it.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        sum_d = $signed({acc_in[ACC_WIDTH-1], acc_in}) + $signed({bias[ACC_WIDTH-1], bias});

        rnd_d = '0;
        if (s1_shift_q != '0) begin
            rnd_d = RW'(1) << (s1_shift_q - SHIFT_WIDTH'(1));
        end
        r_d = ($signed({s1_sum_q[SW-1], s1_sum_q}) + rnd_d) >>> s1_shift_q;

        relu_r = (s2_relu_q && s2_r_q[RW-1]) ? '0 : s2_r_q;
        sat_d  = 1'b0;
        if (relu_r > MAX_V) begin
            data_d = MAX_V[DATA_WIDTH-1:0];
            sat_d  = 1'b1;
        end else if (relu_r < MIN_V) begin
            data_d = MIN_V[DATA_WIDTH-1:0];
            sat_d  = 1'b1;
        end else begin
            data_d = relu_r[DATA_WIDTH-1:0];
        end

        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + SATCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_relu_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_r_q      <= '0;
            s2_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
            if (adv) begin
                s1_valid_q  <= in_valid;
                s1_sum_q    <= sum_d;
                s1_shift_q  <= shift;
                s1_relu_q   <= relu_en;
                s2_valid_q  <= s1_valid_q;
                s2_r_q      <= r_d;
                s2_relu_q   <= s1_relu_q;
                out_valid_q <= s2_valid_q;
                out_data_q  <= data_d;
                out_sat_q   <= s2_valid_q && sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule
